// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES types, S-box, Rcon and GF(2^8) helpers shared by the iterative cipher
package aes_pkg;

   typedef logic [7:0]             byte_t;
   typedef logic [0:3][7:0]        word_t;
   typedef logic [0:3][0:3][7:0]   state_t;   // [column][row]

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_KEXP,
      ST_ROUND,
      ST_DONE
   } fsm_e;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:10][7:0] RCON = {
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic word_t sub_word(input word_t w);
      word_t r;
      for (int b = 0; b < 4; b++) r[b] = SBOX[w[b]];
      return r;
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[1], w[2], w[3], w[0]};
   endfunction

endpackage

// File: rtl/aes_cipher_iter_if.sv
// rtl/aes_cipher_iter_if.sv - request/response handshake bundle for the iterative AES engine
interface aes_cipher_iter_if #(parameter int NK = 4);
   import aes_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic [0:NK-1][0:3][7:0]  key;
   state_t                   data;
   logic                     out_valid;
   logic                     out_ready;
   state_t                   o;

   modport master (
      output in_valid, key, data, out_ready,
      input  in_ready, out_valid, o
   );

   modport slave (
      input  in_valid, key, data, out_ready,
      output in_ready, out_valid, o
   );

endinterface

// File: rtl/aes_round_comb.sv
// rtl/aes_round_comb.sv - one combinational AES round; MixColumns bypassed on the final round
module aes_round_comb
   import aes_pkg::*;
(
   input  state_t st_i,
   input  state_t rk_i,
   input  logic   last_i,
   output state_t st_o
);

   state_t sb;
   state_t sr;
   state_t mc;

   always_comb begin
      sb = '0;
      sr = '0;
      mc = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sb[c][r] = SBOX[st_i[c][r]];
      // row r rotates left by r columns
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[c][r] = sb[(c + r) % 4][r];
      for (int c = 0; c < 4; c++) begin
         mc[c][0] = xtime(sr[c][0]) ^ xtime(sr[c][1]) ^ sr[c][1] ^ sr[c][2] ^ sr[c][3];
         mc[c][1] = sr[c][0] ^ xtime(sr[c][1]) ^ xtime(sr[c][2]) ^ sr[c][2] ^ sr[c][3];
         mc[c][2] = sr[c][0] ^ sr[c][1] ^ xtime(sr[c][2]) ^ xtime(sr[c][3]) ^ sr[c][3];
         mc[c][3] = xtime(sr[c][0]) ^ sr[c][0] ^ sr[c][1] ^ sr[c][2] ^ xtime(sr[c][3]);
      end
      st_o = (last_i ? sr : mc) ^ rk_i;
   end

endmodule

// File: rtl/aes_cipher_iter.sv
// rtl/aes_cipher_iter.sv - iterative AES-128/192/256 encryptor: key expansion then one round per cycle
// Optional AES_KEY_CACHE_EN reuses the expanded schedule when the same key arrives again.
module aes_cipher_iter
   import aes_pkg::*;
#(
   parameter int NK = 4
) (
   input  logic              clk,
   input  logic              rst,
   aes_cipher_iter_if.slave  bus
);

   localparam int NR = NK + 6;
   localparam int WN = 4 * (NR + 1);
   localparam int IW = $clog2(WN);

   if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("aes_cipher_iter: NK must be 4, 6 or 8");
   end

   fsm_e            state_q, state_d;
   logic [IW-1:0]   i_q, i_d;
   logic [3:0]      r_q, r_d;
   logic [2:0]      kidx_q, kidx_d;   // i mod NK
   logic [3:0]      rc_q, rc_d;       // i / NK
   word_t           w_q [WN];
   word_t           w_d [WN];
   state_t          st_q, st_d;
   state_t          o_q, o_d;
   state_t          rk;
   state_t          round_out;
   word_t           temp;
   logic [IW-1:0]   rk_base;

`ifdef AES_KEY_CACHE_EN
   logic [0:NK-1][0:3][7:0]  ckey_q, ckey_d;
   logic                     sv_q, sv_d;
   logic                     hit;
`endif

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.o         = o_q;

   assign rk_base = IW'({r_q, 2'b00});

   always_comb begin
      rk = '0;
      for (int c = 0; c < 4; c++) rk[c] = w_q[rk_base + IW'(c)];
   end

   aes_round_comb u_round (
      .st_i   (st_q),
      .rk_i   (rk),
      .last_i (r_q == 4'(NR)),
      .st_o   (round_out)
   );

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      r_d     = r_q;
      kidx_d  = kidx_q;
      rc_d    = rc_q;
      w_d     = w_q;
      st_d    = st_q;
      o_d     = o_q;
      temp    = '0;
`ifdef AES_KEY_CACHE_EN
      ckey_d  = ckey_q;
      sv_d    = sv_q;
      hit     = sv_q && (bus.key == ckey_q);
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               for (int w = 0; w < NK; w++) w_d[w] = bus.key[w];
               st_d    = bus.data;
               i_d     = IW'(NK);
               kidx_d  = '0;
               rc_d    = 4'd1;
               r_d     = '0;
               state_d = ST_KEXP;
`ifdef AES_KEY_CACHE_EN
               if (hit) begin
                  state_d = ST_ROUND;
               end else begin
                  ckey_d = bus.key;
                  sv_d   = 1'b0;
               end
`endif
            end
         end
         ST_KEXP: begin
            temp = w_q[i_q - IW'(1)];
            if (kidx_q == 3'd0)
               temp = sub_word(rot_word(temp)) ^ {RCON[rc_q], 24'h000000};
            else if (NK == 8 && kidx_q == 3'd4)
               temp = sub_word(temp);
            w_d[i_q] = w_q[i_q - IW'(NK)] ^ temp;
            i_d = i_q + IW'(1);
            if (kidx_q == 3'(NK - 1)) begin
               kidx_d = '0;
               rc_d   = rc_q + 4'd1;
            end else begin
               kidx_d = kidx_q + 3'd1;
            end
            if (i_q == IW'(WN - 1)) begin
               state_d = ST_ROUND;
               r_d     = '0;
`ifdef AES_KEY_CACHE_EN
               sv_d    = 1'b1;
`endif
            end
         end
         ST_ROUND: begin
            st_d = (r_q == 4'd0) ? (st_q ^ rk) : round_out;
            r_d  = r_q + 4'd1;
            if (r_q == 4'(NR)) begin
               o_d     = round_out;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         r_q     <= '0;
         kidx_q  <= '0;
         rc_q    <= '0;
         st_q    <= '0;
         o_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         r_q     <= r_d;
         kidx_q  <= kidx_d;
         rc_q    <= rc_d;
         st_q    <= st_d;
         o_q     <= o_d;
      end
   end

   // schedule contents are don't-care after reset, so no reset term
   always_ff @(posedge clk) begin
      w_q <= w_d;
   end

`ifdef AES_KEY_CACHE_EN
   always_ff @(posedge clk) begin
      ckey_q <= ckey_d;
      if (rst) sv_q <= 1'b0;
      else     sv_q <= sv_d;
   end
`endif

endmodule
